// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NREQ byte requesters.
// A granted byte is strobed to the UART until it starts, then the line is allowed to drain.
module uart_tx_scheduler #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              uart_transmit,
  output logic [7:0]        uart_tx_byte,
  input  logic              uart_is_transmitting,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             timeout_q, timeout_d;

  logic             any_req;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] pick;
  logic [7:0]       pick_byte;
  logic [IDX_W-1:0] grant_next;
  logic [CNT_W-1:0] cnt_inc;

  // First pending requester at or above rr_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    any_req = 1'b0;
    cand    = rr_ptr_q;
    pick    = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    pick_byte = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (IDX_W'(k) == pick) pick_byte = req_data[8*k +: 8];
    end
  end

  assign grant_next = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    ack_d     = '0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d   = pick;
          tx_byte_d = pick_byte;
          cnt_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        // A UART that is already busy on the first START cycle counts as having accepted the byte.
        if (uart_is_transmitting) begin
          ack_d[grant_q] = 1'b1;
          rr_ptr_d       = grant_next;
          cnt_d          = '0;
          state_d        = DRAIN;
        end else if (cnt_inc == CNT_W'(START_TIMEOUT)) begin
          timeout_d = 1'b1;
          rr_ptr_d  = grant_next;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DRAIN: begin
        if (!uart_is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      tx_byte_q <= 8'h00;
      ack_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  assign ack           = ack_q;
  assign timeout_err   = timeout_q;
  assign uart_tx_byte  = tx_byte_q;
  assign uart_transmit = (state_q == START);
  assign busy          = (state_q != IDLE);

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ack_q));
  a_ack_excl:   assert property (@(posedge clk) disable iff (reset) !((|ack_q) && timeout_q));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a cycle-level UART model plus requesters driven from tasks.
// Outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_scheduler;

  localparam int NREQ          = 4;
  localparam int START_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              uart_is_transmitting;
  logic              busy;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  // UART model: raises busy after seeing uart_transmit for uart_lat samples (0 = never),
  // holds it for uart_hold samples once the strobe drops. uart_manual hands the line to the tasks.
  int   uart_lat, uart_hold, seen_cnt, hold_cnt;
  bit   uart_manual;
  bit   auto_drop;

  int         tx_cycles, timeout_cnt, total_acks;
  int         ack_cnt [NREQ];
  logic [7:0] sent_q [$];

  uart_tx_scheduler #(
    .NREQ         (NREQ),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req                 (req),
    .req_data            (req_data),
    .ack                 (ack),
    .uart_transmit       (uart_transmit),
    .uart_tx_byte        (uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .busy                (busy),
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic clear_log();
    tx_cycles   = 0;
    timeout_cnt = 0;
    total_acks  = 0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    sent_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0(ack) || ((|ack) && timeout_err)) begin
      errors++;
      $display("FAIL ack_exclusive: ack=%b timeout_err=%b, required at most one ack bit and never with timeout_err",
               ack, timeout_err);
    end
    if (uart_transmit === 1'b1) tx_cycles++;
    if (timeout_err === 1'b1) timeout_cnt++;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] === 1'b1) begin
        ack_cnt[i]++;
        total_acks++;
        sent_q.push_back(uart_tx_byte);
        if (auto_drop) req[i] = 1'b0;
      end
    end
    if (!uart_manual) begin
      if (uart_is_transmitting) begin
        if (uart_transmit !== 1'b1) begin
          if (hold_cnt <= 1) uart_is_transmitting = 1'b0;
          else hold_cnt--;
        end
      end else if (uart_transmit === 1'b1 && uart_lat > 0) begin
        seen_cnt++;
        if (seen_cnt >= uart_lat) begin
          uart_is_transmitting = 1'b1;
          hold_cnt = uart_hold;
          seen_cnt = 0;
        end
      end
    end
  endtask

  task automatic reset_dut();
    reset                = 1'b1;
    req                  = '0;
    uart_is_transmitting = 1'b0;
    uart_manual          = 1'b0;
    seen_cnt             = 0;
    hold_cnt             = 0;
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int cyc = 0;
    while (total_acks < n && cyc < budget) begin
      tick();
      cyc++;
    end
    checks++;
    if (total_acks < n) begin
      errors++;
      $display("FAIL %s: ack count %0d after %0d cycles, required %0d", tag, total_acks, cyc, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int cyc = 0;
    while ((busy !== 1'b0 || uart_is_transmitting) && cyc < budget) begin
      tick();
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, busy, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    req_data = '0;
    uart_is_transmitting = 1'b0;
    tick();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b, required 0000", ack); end
    checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b, required 0", uart_transmit); end
    checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h, required 00", uart_tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", timeout_err); end
    reset = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || uart_transmit !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: busy=%b transmit=%b, required 0/0", busy, uart_transmit);
    end
  endtask

  task automatic test_single();
    reset_dut();
    uart_lat = 2; uart_hold = 3; auto_drop = 1'b1;
    req_data = 32'h0000_0041;
    req = 4'b0001;
    tick();
    checks++; if (uart_transmit !== 1'b1) begin errors++; $display("FAIL single_latency: transmit=%b, required 1", uart_transmit); end
    checks++; if (uart_tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte: got %h, required 41", uart_tx_byte); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
    wait_acks(1, 20, "single_ack");
    wait_idle(20, "single_idle");
    checks++; if (tx_cycles != 2) begin errors++; $display("FAIL single_tx_cycles: got %0d, required 2", tx_cycles); end
    checks++; if (ack_cnt[0] != 1 || total_acks != 1) begin
      errors++; $display("FAIL single_ack_count: req0=%0d total=%0d, required 1/1", ack_cnt[0], total_acks);
    end
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'h41) begin
      errors++; $display("FAIL single_sent: size=%0d, required one byte 41", sent_q.size());
    end
    checks++; if (uart_tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte_hold: got %h, required 41", uart_tx_byte); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [5];
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    reset_dut();
    uart_lat = 2; uart_hold = 3; auto_drop = 1'b0;
    req_data = 32'h1312_1110;
    req = 4'b1111;
    wait_acks(5, 60, "rr_acks");
    req = '0;
    wait_idle(20, "rr_idle");
    checks++;
    if (sent_q.size() != 5) begin
      errors++; $display("FAIL rr_count: got %0d bytes, required 5", sent_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sent_q[i] !== exp[i]) begin
          errors++; $display("FAIL rr_order[%0d]: got %h, required %h", i, sent_q[i], exp[i]);
        end
      end
    end
    checks++; if (ack_cnt[0] != 2 || ack_cnt[1] != 1 || ack_cnt[2] != 1 || ack_cnt[3] != 1) begin
      errors++; $display("FAIL rr_ack_counts: got %0d/%0d/%0d/%0d, required 2/1/1/1",
                         ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    uart_lat = 2; uart_hold = 3; auto_drop = 1'b1;
    req_data = 32'h0000_A1A0;
    req = 4'b0010;
    wait_acks(1, 20, "wrap_setup");
    wait_idle(20, "wrap_setup_idle");
    clear_log();
    req = 4'b0011;
    wait_acks(2, 40, "wrap_acks");
    wait_idle(20, "wrap_idle");
    checks++;
    if (sent_q.size() != 2 || sent_q[0] !== 8'hA0 || sent_q[1] !== 8'hA1) begin
      errors++; $display("FAIL wrap_order: size=%0d, required A0 then A1", sent_q.size());
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    reset_dut();
    uart_lat = 0; uart_hold = 2; auto_drop = 1'b1;
    req_data = 32'h0000_B1B0;
    req = 4'b0011;
    while (timeout_cnt == 0 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: timeout_err=%b after %0d cycles, required 1", timeout_err, cyc); end
    checks++; if (tx_cycles != START_TIMEOUT) begin errors++; $display("FAIL to_tx_cycles: got %0d, required %0d", tx_cycles, START_TIMEOUT); end
    checks++; if (total_acks != 0 || uart_transmit !== 1'b0) begin
      errors++; $display("FAIL to_no_ack: acks=%0d transmit=%b, required 0/0", total_acks, uart_transmit);
    end
    uart_lat = 1;
    tick();
    checks++; if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'hB1) begin
      errors++; $display("FAIL to_next_grant: transmit=%b byte=%h, required 1/B1", uart_transmit, uart_tx_byte);
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_single_pulse: got %b, required 0", timeout_err); end
    wait_acks(2, 40, "to_retry_acks");
    wait_idle(20, "to_idle");
    checks++; if (sent_q.size() != 2 || sent_q[0] !== 8'hB1 || sent_q[1] !== 8'hB0) begin
      errors++; $display("FAIL to_retry_order: size=%0d, required B1 then B0", sent_q.size());
    end
    checks++; if (timeout_cnt != 1) begin errors++; $display("FAIL to_count: got %0d, required 1", timeout_cnt); end
  endtask

  task automatic test_already_busy();
    reset_dut();
    auto_drop = 1'b1;
    uart_manual = 1'b1;
    uart_is_transmitting = 1'b1;
    req_data = 32'h0000_00C3;
    req = 4'b0001;
    tick();
    checks++; if (uart_transmit !== 1'b1 || total_acks != 0) begin
      errors++; $display("FAIL ab_start: transmit=%b acks=%0d, required 1/0", uart_transmit, total_acks);
    end
    tick();
    checks++; if (ack !== 4'b0001 || uart_transmit !== 1'b0) begin
      errors++; $display("FAIL ab_ack: ack=%b transmit=%b, required 0001/0", ack, uart_transmit);
    end
    uart_is_transmitting = 1'b0;
    wait_idle(10, "ab_idle");
    checks++; if (tx_cycles != 1 || total_acks != 1) begin
      errors++; $display("FAIL ab_counts: tx_cycles=%0d acks=%0d, required 1/1", tx_cycles, total_acks);
    end
  endtask

  task automatic test_reset_mid_start();
    reset_dut();
    uart_lat = 0; auto_drop = 1'b1;
    req_data = 32'h0000_00E0;
    req = 4'b0001;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (uart_transmit !== 1'b0 || busy !== 1'b0 || uart_tx_byte !== 8'h00) begin
      errors++; $display("FAIL rst_start: transmit=%b busy=%b byte=%h, required 0/0/00", uart_transmit, busy, uart_tx_byte);
    end
    req = '0;
    reset = 1'b0;
    tick(); tick();
    checks++; if (total_acks != 0 || timeout_cnt != 0) begin
      errors++; $display("FAIL rst_start_pulses: acks=%0d timeouts=%0d, required 0/0", total_acks, timeout_cnt);
    end
  endtask

  task automatic test_reset_in_drain();
    reset_dut();
    uart_lat = 2; uart_hold = 3; auto_drop = 1'b1;
    req_data = 32'h00D2_00D0;
    req = 4'b0101;
    wait_acks(1, 20, "drain_first_ack");
    checks++; if (busy !== 1'b1 || req !== 4'b0100) begin
      errors++; $display("FAIL drain_state: busy=%b req=%b, required 1/0100", busy, req);
    end
    reset = 1'b1;
    uart_is_transmitting = 1'b0;
    seen_cnt = 0;
    tick();
    checks++; if (ack !== 4'b0000 || timeout_err !== 1'b0 || uart_transmit !== 1'b0) begin
      errors++; $display("FAIL drain_rst_pulses: ack=%b timeout=%b transmit=%b, required 0000/0/0", ack, timeout_err, uart_transmit);
    end
    checks++; if (busy !== 1'b0 || uart_tx_byte !== 8'h00) begin
      errors++; $display("FAIL drain_rst_state: busy=%b byte=%h, required 0/00", busy, uart_tx_byte);
    end
    reset = 1'b0;
    tick();
    checks++; if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'hD2) begin
      errors++; $display("FAIL drain_regrant: transmit=%b byte=%h, required 1/D2", uart_transmit, uart_tx_byte);
    end
    wait_acks(2, 30, "drain_regrant_ack");
    wait_idle(20, "drain_idle");
    checks++; if (ack_cnt[0] != 1 || ack_cnt[2] != 1) begin
      errors++; $display("FAIL drain_ack_counts: req0=%0d req2=%0d, required 1/1", ack_cnt[0], ack_cnt[2]);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_data = '0;
    uart_is_transmitting = 1'b0;
    uart_manual = 1'b0;
    auto_drop = 1'b1;
    uart_lat = 0;
    uart_hold = 0;
    seen_cnt = 0;
    hold_cnt = 0;
    clear_log();

    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_already_busy();
    test_reset_mid_start();
    test_reset_in_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters sharing the UART transmitter (2..8).
REQ-002 Parameter START_TIMEOUT, default 16, max cycles uart_transmit is held waiting for uart_is_transmitting to rise.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  reset reset, synchronous, active-high; clock clk.
REQ-005 Port req  input  NREQ  per-requester level request; held high until matching ack.
REQ-006 Port req_data  input  8*NREQ  requester i byte at bits [8i+7:8i]; stable while req[i] high.
REQ-007 Port ack  output  NREQ  one-cycle pulse: requester's byte accepted by UART.
REQ-008 Port uart_transmit  output  1  start-transmit strobe to UART.
REQ-009 Port uart_tx_byte  output  8  byte presented to UART.
REQ-010 Port uart_is_transmitting  input  1  UART transmit-line-busy status.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port timeout_err  output  1  one-cycle pulse: UART failed to start within START_TIMEOUT.

Function
REQ-013 FSM states SHALL be IDLE, START, DRAIN; one-hot or binary encoding is free.
REQ-014 IDLE: if any req bit high, SHALL grant the first set bit searching upward from pointer rr_ptr with wrap-around NREQ-1 -> 0, latch its byte into uart_tx_byte, store grant index, go START.
REQ-015 Latency: req[i] high in IDLE at edge n -> uart_transmit=1 and uart_tx_byte valid after edge n+1.
REQ-016 START: uart_transmit SHALL be 1; timeout counter increments each cycle.
REQ-017 START with uart_is_transmitting=1: uart_transmit -> 0, ack[grant] pulses one cycle, rr_ptr <- (grant+1) mod NREQ, go DRAIN.
REQ-018 START with counter reaching START_TIMEOUT and uart_is_transmitting=0: uart_transmit -> 0, timeout_err pulses one cycle, no ack, rr_ptr <- (grant+1) mod NREQ, go IDLE; request stays pending and is retried on its next turn.
REQ-019 DRAIN: wait for uart_is_transmitting=0, then go IDLE; arbitration resumes the cycle after IDLE is entered (no combinational grant from DRAIN).
REQ-020 uart_tx_byte SHALL hold its latched value from START through DRAIN and until the next grant.
REQ-021 req[grant] dropping during START/DRAIN (protocol violation) SHALL NOT abort; byte still sent, ack still pulsed.
REQ-022 At most one ack bit SHALL be high in any cycle; ack and timeout_err never high together.
REQ-023 Requests not granted SHALL NOT be lost; any continuously asserted req is granted within NREQ grants (no starvation).
REQ-024 uart_is_transmitting already high on START entry SHALL count as accepted on the first START cycle.

Reset
REQ-025 On reset: state IDLE, rr_ptr=0, counter=0, uart_transmit=0, uart_tx_byte=8'h00, ack=0, busy=0, timeout_err=0.
REQ-026 Reset asserted mid-START or mid-DRAIN SHALL force reset values at the next edge; no ack or timeout_err pulse emitted.
REQ-027 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-028 After reset, req=4'b0001, byte0=8'h41, UART model raises busy 2 cycles after transmit -> uart_transmit high 2 cycles, uart_tx_byte=8'h41, single ack=4'b0001 pulse, busy low after UART idle.
REQ-029 req=4'b1111 held, bytes 8'h10/11/12/13 -> transmission order 10,11,12,13,10 with rr wrap; each ack exactly once per byte.
REQ-030 rr_ptr=2, req=4'b0011 -> requester 0 granted first (wrap search), then 1.
REQ-031 UART model never raises busy, START_TIMEOUT=16 -> uart_transmit high 16 cycles, one timeout_err pulse, no ack, next grant goes to next requester.
REQ-032 reset pulsed while in DRAIN with req=4'b0100 pending -> all outputs at reset values next cycle; after release requester 2 regranted with rr_ptr=0 search.
REQ-033 uart_is_transmitting already high at START entry -> ack on first START cycle, uart_transmit high exactly one cycle.
